// File: rtl/frame_scanner_if.sv
// -----------------------------------------------------------------------------
// frame_scanner_if
// Bundles the run control, channel snapshot inputs and the time-multiplexed
// debug output of frame_scanner. The "master" side drives the channel words and
// run control and observes the output bus. The "slave" side is the scanner.
// -----------------------------------------------------------------------------
interface frame_scanner_if #(
  parameter int DATA_W = 8,
  parameter int N_CH   = 8
);
  localparam int CH_W = $clog2(N_CH + 1);

  logic                     enable;
  logic [N_CH*DATA_W-1:0]   ch_data;
  logic [N_CH-1:0]          ch_mask;
  logic [DATA_W-1:0]        dout;
  logic [CH_W-1:0]          dout_ch;
  logic                     dout_valid;
  logic                     frame_start;
  logic                     busy;

  modport master (
    output enable, ch_data, ch_mask,
    input  dout, dout_ch, dout_valid, frame_start, busy
  );

  modport slave (
    input  enable, ch_data, ch_mask,
    output dout, dout_ch, dout_valid, frame_start, busy
  );
endinterface

// File: rtl/frame_scanner.sv
// -----------------------------------------------------------------------------
// frame_scanner
// Time-multiplexed channel broadcaster for scope / logic-analyser debug.
// At each frame start a coherent snapshot of all channel words is taken; the
// enabled channels are then replayed in ascending index order, one per slot of
// SLOT_CYCLES clocks, with a frame-sync strobe for scope triggering.
//
// Optional feature macro: FRAME_CHECKSUM_EN
//   When defined, every frame carries one extra slot after the last channel
//   holding the XOR of the snapshot words of all enabled channels, tagged with
//   channel index N_CH.
// -----------------------------------------------------------------------------
module frame_scanner #(
  parameter int DATA_W      = 8,
  parameter int N_CH        = 8,
  parameter int SLOT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  frame_scanner_if.slave  bus
);

  localparam int CH_W  = $clog2(N_CH + 1);
  localparam int CNT_W = $clog2(SLOT_CYCLES);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SLOT = 1'b1;

  // Reject configurations the slot sequencing cannot support.
  if (N_CH < 2) begin : g_bad_nch
    $error("frame_scanner: N_CH must be at least 2");
  end
  if (SLOT_CYCLES < 2) begin : g_bad_slot
    $error("frame_scanner: SLOT_CYCLES must be at least 2");
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [0:0]         r_state;
  logic [DATA_W-1:0]  r_shadow [N_CH];
  logic [N_CH-1:0]    r_mask;
  logic [CNT_W-1:0]   r_slot_cnt;
  logic [DATA_W-1:0]  r_dout;
  logic [CH_W-1:0]    r_dout_ch;
  logic               r_dout_valid;
  logic               r_frame_start;
  logic               r_busy;

`ifdef FRAME_CHECKSUM_EN
  logic               r_in_cks;
  logic [DATA_W-1:0]  w_cks;
`endif

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic [CH_W-1:0]    w_first_idx;
  logic [DATA_W-1:0]  w_first_data;
  logic               w_has_next;
  logic [CH_W-1:0]    w_next_idx;
  logic [DATA_W-1:0]  w_next_data;
  logic               w_slot_last;
  logic               w_frame_end;
  logic               w_start;

  // Lowest set bit of the live mask and its live data word (first slot source).
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned; otherwise a latch is inferred.
    w_first_idx  = '0;
    w_first_data = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (bus.ch_mask[i]) begin
        w_first_idx  = CH_W'(i);
        w_first_data = bus.ch_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next higher enabled channel above the one currently on dout, from shadows.
  // In the checksum slot dout_ch is N_CH, so no channel qualifies.
  always_comb begin
    w_has_next  = 1'b0;
    w_next_idx  = '0;
    w_next_data = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (r_mask[i] && (CH_W'(i) > r_dout_ch)) begin
        w_has_next  = 1'b1;
        w_next_idx  = CH_W'(i);
        w_next_data = r_shadow[i];
      end
    end
  end

`ifdef FRAME_CHECKSUM_EN
  // XOR of the snapshot words of every channel enabled for this frame.
  always_comb begin
    w_cks = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (r_mask[i]) begin
        w_cks = w_cks ^ r_shadow[i];
      end
    end
  end
`endif

  assign w_slot_last = (r_slot_cnt == CNT_W'(SLOT_CYCLES - 1));

  // The frame ends on the last cycle of its final slot: the last channel, or
  // the checksum slot when that feature is built in.
`ifdef FRAME_CHECKSUM_EN
  assign w_frame_end = (r_state == S_SLOT) && w_slot_last && !w_has_next && r_in_cks;
`else
  assign w_frame_end = (r_state == S_SLOT) && w_slot_last && !w_has_next;
`endif

  // Run control and mask are only honoured at frame boundaries.
  assign w_start = bus.enable && (|bus.ch_mask) &&
                   ((r_state == S_IDLE) || w_frame_end);

  // ---------------------------------------------------------------------------
  // Snapshot capture
  // ---------------------------------------------------------------------------
  // Latch every channel word and the mask at a frame-start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the shadow words are observable (checksum, idle hold) and must
      // come up defined, so this small register array is reset explicitly.
      for (int i = 0; i < N_CH; i++) begin
        r_shadow[i] <= '0;
      end
      r_mask <= '0;
    end else if (w_start) begin
      for (int i = 0; i < N_CH; i++) begin
        r_shadow[i] <= bus.ch_data[i*DATA_W +: DATA_W];
      end
      r_mask <= bus.ch_mask;
    end
  end

  // ---------------------------------------------------------------------------
  // Slot sequencer and output registers
  // ---------------------------------------------------------------------------
  // Advance the slot counter and reload the output word at each slot boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: state is updated with non-blocking assignments so every register
      // in the block sees pre-edge values, matching real flip-flop behaviour.
      r_state       <= S_IDLE;
      r_slot_cnt    <= '0;
      r_dout        <= '0;
      r_dout_ch     <= '0;
      r_dout_valid  <= 1'b0;
      r_frame_start <= 1'b0;
      r_busy        <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
      r_in_cks      <= 1'b0;
`endif
    end else begin
      r_dout_valid <= 1'b0;
      if (w_start) begin
        // First slot comes from live data; it equals the snapshot being taken.
        r_state       <= S_SLOT;
        r_slot_cnt    <= '0;
        r_dout        <= w_first_data;
        r_dout_ch     <= w_first_idx;
        r_dout_valid  <= 1'b1;
        r_frame_start <= 1'b1;
        r_busy        <= 1'b1;
`ifdef FRAME_CHECKSUM_EN
        r_in_cks      <= 1'b0;
`endif
      end else if (r_state == S_SLOT) begin
        if (!w_slot_last) begin
          r_slot_cnt <= r_slot_cnt + 1'b1;
        end else if (w_has_next) begin
          r_slot_cnt    <= '0;
          r_dout        <= w_next_data;
          r_dout_ch     <= w_next_idx;
          r_dout_valid  <= 1'b1;
          r_frame_start <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
        end else if (!r_in_cks) begin
          r_slot_cnt    <= '0;
          r_dout        <= w_cks;
          r_dout_ch     <= CH_W'(N_CH);
          r_dout_valid  <= 1'b1;
          r_frame_start <= 1'b0;
          r_in_cks      <= 1'b1;
`endif
        end else begin
          // Frame over with no restart: dout and dout_ch keep their last value.
          r_state       <= S_IDLE;
          r_slot_cnt    <= '0;
          r_frame_start <= 1'b0;
          r_busy        <= 1'b0;
        end
      end
    end
  end

  assign bus.dout        = r_dout;
  assign bus.dout_ch     = r_dout_ch;
  assign bus.dout_valid  = r_dout_valid;
  assign bus.frame_start = r_frame_start;
  assign bus.busy        = r_busy;

endmodule

// File: tb/tb_frame_scanner.sv
// -----------------------------------------------------------------------------
// tb_frame_scanner
// Self-checking bench for frame_scanner (N_CH=4, DATA_W=8, SLOT_CYCLES=4).
// A frame-level reference model builds each frame's slot list from the inputs
// at the start edge and derives every output from the position in the frame.
// Honours FRAME_CHECKSUM_EN when defined.
// -----------------------------------------------------------------------------
module tb_frame_scanner;

  localparam int DW = 8;
  localparam int NC = 4;
  localparam int SC = 4;
`ifdef FRAME_CHECKSUM_EN
  localparam int CKS = 1;
`else
  localparam int CKS = 0;
`endif
  localparam int FLEN = (NC + CKS) * SC;  // full-mask frame length

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  frame_scanner_if #(.DATA_W(DW), .N_CH(NC)) bus ();

  frame_scanner #(.DATA_W(DW), .N_CH(NC), .SLOT_CYCLES(SC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = -1;

  // ---------------- reference model ----------------
  int             m_busy;
  int             m_pos;
  int             m_len;
  int             m_ch  [$];
  logic [DW-1:0]  m_dat [$];
  logic [DW-1:0]  e_dout;
  int             e_ch;
  logic           e_valid, e_fs, e_busy;

  task automatic model_reset();
    m_busy = 0; m_pos = 0; m_len = 0;
    m_ch.delete(); m_dat.delete();
    e_dout = '0; e_ch = 0; e_valid = 0; e_fs = 0; e_busy = 0;
  endtask

  // One clock edge: inputs are the values present just before the edge.
  task automatic model_step();
    logic [DW-1:0] x;
    bit start;
    int s;
    start = bus.enable && (bus.ch_mask != 0) && (!m_busy || m_pos == m_len - 1);
    if (start) begin
      m_ch.delete(); m_dat.delete();
      x = '0;
      for (int i = 0; i < NC; i++) begin
        if (bus.ch_mask[i]) begin
          m_ch.push_back(i);
          m_dat.push_back(bus.ch_data[i*DW +: DW]);
          x ^= bus.ch_data[i*DW +: DW];
        end
      end
      if (CKS != 0) begin
        m_ch.push_back(NC);
        m_dat.push_back(x);
      end
      m_len  = m_ch.size() * SC;
      m_pos  = 0;
      m_busy = 1;
    end else if (m_busy != 0) begin
      if (m_pos == m_len - 1) m_busy = 0;
      else m_pos++;
    end
    if (m_busy != 0) begin
      s       = m_pos / SC;
      e_dout  = m_dat[s];
      e_ch    = m_ch[s];
      e_valid = (m_pos % SC == 0);
      e_fs    = (s == 0);
      e_busy  = 1;
    end else begin
      e_valid = 0; e_fs = 0; e_busy = 0;
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic compare_all();
    check("dout",        32'(bus.dout),        32'(e_dout));
    check("dout_ch",     32'(bus.dout_ch),     32'(e_ch));
    check("dout_valid",  32'(bus.dout_valid),  32'(e_valid));
    check("frame_start", 32'(bus.frame_start), 32'(e_fs));
    check("busy",        32'(bus.busy),        32'(e_busy));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_dout"},  32'(bus.dout),        0);
    check({tag, "_ch"},    32'(bus.dout_ch),     0);
    check({tag, "_valid"}, 32'(bus.dout_valid),  0);
    check({tag, "_fs"},    32'(bus.frame_start), 0);
    check({tag, "_busy"},  32'(bus.busy),        0);
  endtask

  // Advance one clock: model follows the edge, outputs sampled at the negedge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    compare_all();
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic set_word(input int i, input logic [DW-1:0] v);
    bus.ch_data[i*DW +: DW] = v;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.enable = 1'b0;
    #1;
    model_reset();
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Asynchronous reset between edges; outputs must clear without a clock.
  task automatic mid_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic start_scn(input logic [NC-1:0] mask);
    do_reset();
    set_word(0, 8'h11); set_word(1, 8'h22); set_word(2, 8'h33); set_word(3, 8'h44);
    bus.ch_mask = mask;
    bus.enable  = 1'b1;
    cyc = -1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int            cyc;
    logic [DW-1:0] dout;
    int            ch;
    logic          valid;
    logic          fs;
    logic          busy;
  } vec_t;

  vec_t tbl[$];

  task automatic add_vec(input int c, input logic [DW-1:0] d, input int ch,
                         input logic v, input logic fs, input logic b);
    vec_t e;
    e.cyc = c; e.dout = d; e.ch = ch; e.valid = v; e.fs = fs; e.busy = b;
    tbl.push_back(e);
  endtask

  initial begin
    int vcount;

    // Full-scan expectations, mask=1111, enable held high from edge 0.
    add_vec( 0, 8'h11, 0, 1, 1, 1);
    add_vec( 1, 8'h11, 0, 0, 1, 1);
    add_vec( 3, 8'h11, 0, 0, 1, 1);
    add_vec( 4, 8'h22, 1, 1, 0, 1);
    add_vec( 5, 8'h22, 1, 0, 0, 1);
    add_vec( 8, 8'h33, 2, 1, 0, 1);
    add_vec(12, 8'h44, 3, 1, 0, 1);
    add_vec(15, 8'h44, 3, 0, 0, 1);
`ifdef FRAME_CHECKSUM_EN
    add_vec(16, 8'h44, 4, 1, 0, 1);
    add_vec(19, 8'h44, 4, 0, 0, 1);
    add_vec(20, 8'h11, 0, 1, 1, 1);
`else
    add_vec(16, 8'h11, 0, 1, 1, 1);
    add_vec(17, 8'h11, 0, 0, 1, 1);
`endif

    bus.enable  = 1'b0;
    bus.ch_mask = '0;
    bus.ch_data = '0;
    model_reset();
    #2;

    // Full scan driven from the table.
    start_scn(4'b1111);
    for (int k = 0; k < tbl.size(); k++) begin
      run_to(tbl[k].cyc);
      check("tbl_dout",  32'(bus.dout),        32'(tbl[k].dout));
      check("tbl_ch",    32'(bus.dout_ch),     32'(tbl[k].ch));
      check("tbl_valid", 32'(bus.dout_valid),  32'(tbl[k].valid));
      check("tbl_fs",    32'(bus.frame_start), 32'(tbl[k].fs));
      check("tbl_busy",  32'(bus.busy),        32'(tbl[k].busy));
    end

    // Masking: channels 1 and 3 only.
    start_scn(4'b1010);
    run_to(0);
    check("mask_ch0",  32'(bus.dout_ch), 1);
    check("mask_d0",   32'(bus.dout),    32'h22);
    run_to(3);
    check("mask_fs3",  32'(bus.frame_start), 1);
    run_to(4);
    check("mask_ch4",  32'(bus.dout_ch), 3);
    check("mask_d4",   32'(bus.dout),    32'h44);
    check("mask_fs4",  32'(bus.frame_start), 0);
    run_to(8);
    check("mask_ch8",  32'(bus.dout_ch), (CKS != 0) ? NC : 1);
    check("mask_d8",   32'(bus.dout),    (CKS != 0) ? 32'h66 : 32'h22);

    // Coherence: ch2 changes mid-frame, visible only in the next frame.
    start_scn(4'b1111);
    run_to(2);
    set_word(2, 8'hAA);
    run_to(8);
    check("coh_old",  32'(bus.dout), 32'h33);
    run_to(FLEN + 8);
    check("coh_new",  32'(bus.dout), 32'hAA);

    // Stop: enable dropped mid-frame, frame completes, outputs hold.
    start_scn(4'b1111);
    run_to(5);
    bus.enable = 1'b0;
    run_to(FLEN - 1);
    check("stop_busy_last", 32'(bus.busy), 1);
    run_to(FLEN);
    check("stop_busy",  32'(bus.busy),       0);
    check("stop_hold",  32'(bus.dout),       32'h44);
    check("stop_valid", 32'(bus.dout_valid), 0);
    run_to(FLEN + 6);
    check("stop_idle",  32'(bus.busy),       0);

    // Asynchronous reset mid-frame, then restart from a fresh frame.
    start_scn(4'b1111);
    run_to(6);
    mid_reset();
    cyc = -1;
    run_to(0);
    check("rst_restart_fs", 32'(bus.frame_start), 1);
    check("rst_restart_ch", 32'(bus.dout_ch),     0);

    // Empty mask with enable: nothing happens.
    start_scn(4'b0000);
    vcount = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.dout_valid) vcount++;
    end
    check("mask0_busy",   32'(bus.busy), 0);
    check("mask0_pulses", 32'(vcount),   0);

    // Randomised traffic against the model.
    do_reset();
    cyc = -1;
    for (int n = 0; n < 1500; n++) begin
      bus.enable = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 9) == 0) bus.ch_mask = NC'($urandom_range(0, (1 << NC) - 1));
      if ($urandom_range(0, 2) == 0) set_word($urandom_range(0, NC - 1), DW'($urandom));
      if ($urandom_range(0, 299) == 0) mid_reset();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
